// File: rtl/bnn_seq_if.sv
// bnn_seq_if: start/config/result signals of bnn_seq_ctrl; BNN_TRACE_EN adds the trace outputs
interface bnn_seq_if;
    logic        start;
    logic [7:0]  x_in;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [11:0] cfg_wdata;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [7:0]  y_out;
`ifdef BNN_TRACE_EN
    logic        trace_valid;
    logic [3:0]  trace_idx;
    logic [3:0]  trace_sum;
    modport master (output start, x_in, cfg_we, cfg_addr, cfg_wdata,
                    input busy, done, cfg_err, y_out, trace_valid, trace_idx, trace_sum);
    modport slave (input start, x_in, cfg_we, cfg_addr, cfg_wdata,
                   output busy, done, cfg_err, y_out, trace_valid, trace_idx, trace_sum);
`else
    modport master (output start, x_in, cfg_we, cfg_addr, cfg_wdata,
                    input busy, done, cfg_err, y_out);
    modport slave (input start, x_in, cfg_we, cfg_addr, cfg_wdata,
                   output busy, done, cfg_err, y_out);
`endif
endinterface

// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl: 8-8-4-4 BNN sequencer, one neuron per cycle on a shared XNOR-popcount unit; BNN_TRACE_EN adds trace outputs
module bnn_seq_ctrl (
    input logic      clk,
    input logic      rst_n,
    input logic      ena,
    bnn_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, L1, L2, L3, DONE} state_t;
    state_t     state, state_nx;
    logic [3:0] idx;
    logic [7:0] x_q, act1, y_q;
    logic [3:0] act2, act3;
    logic [7:0] w_q [16];
    logic [3:0] thr_q [16];
    logic       err_q, busy, cfg_ok;
    logic [7:0] src, agree;
    logic [3:0] sum;
    logic       hit;

    // state register, frozen while ena is low
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else if (ena) state <= state_nx;

    // layer sequencing by neuron index
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? L1 : IDLE;
            L1:      state_nx = idx == 4'd7 ? L2 : L1;
            L2:      state_nx = idx == 4'd11 ? L3 : L2;
            L3:      state_nx = idx == 4'd15 ? DONE : L3;
            default: state_nx = IDLE;
        endcase
    end

    // handshake outputs; pulses are suppressed in frozen cycles
    always_comb begin
        busy        = state == L1 || state == L2 || state == L3;
        cfg_ok      = state == IDLE || state == DONE;
        bus.busy    = busy;
        bus.done    = ena && state == DONE;
        bus.cfg_err = ena && err_q;
        bus.y_out   = y_q;
    end

    // shared neuron: layer 3 only looks at the upper weight nibble against act2
    always_comb begin
        src   = state == L1 ? x_q : state == L2 ? act1 : {act2, 4'h0};
        agree = ~(src ^ w_q[idx]) & (state == L3 ? 8'hF0 : 8'hFF);
        sum   = 4'd0;
        for (int i = 0; i < 8; i++) sum = sum + {3'd0, agree[i]};
        hit   = sum >= thr_q[idx];
    end

    // run datapath: input latch, index, activations and result register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx   <= 4'd0;
            x_q   <= 8'h00;
            act1  <= 8'h00;
            act2  <= 4'h0;
            act3  <= 4'h0;
            y_q   <= 8'h00;
            err_q <= 1'b0;
        end else if (ena) begin
            err_q <= bus.cfg_we && busy;
            if (state == IDLE && bus.start) begin
                x_q <= bus.x_in;
                idx <= 4'd0;
            end
            if (busy) idx <= idx + 4'd1;
            if (state == L1) act1[idx[2:0]] <= hit;
            if (state == L2) act2[idx[1:0]] <= hit;
            if (state == L3) act3[idx[1:0]] <= hit;
            if (state == L3 && idx == 4'd15) y_q <= {hit, act3[2:0], act2};
        end

    // parameter file, writable only outside a run
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i]   <= 8'h00;
                thr_q[i] <= 4'h0;
            end
        end else if (ena && bus.cfg_we && cfg_ok) begin
            {thr_q[bus.cfg_addr], w_q[bus.cfg_addr]} <= bus.cfg_wdata;
        end

`ifdef BNN_TRACE_EN
    // trace of each evaluated neuron, one cycle behind
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.trace_valid <= 1'b0;
            bus.trace_idx   <= 4'd0;
            bus.trace_sum   <= 4'd0;
        end else if (ena) begin
            bus.trace_valid <= busy;
            bus.trace_idx   <= idx;
            bus.trace_sum   <= sum;
        end
`endif
endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// tb_bnn_seq_ctrl: directed self-checking bench for bnn_seq_ctrl
module tb_bnn_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;
    int checks = 0;
    int errors = 0;

    bnn_seq_if bus ();

    bnn_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [11:0] d);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_wdata = d;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    // starts a run from IDLE and measures cycles to done, busy cycles and result
    task automatic do_run(input logic [7:0] x, output int lat, output int bcnt, output logic [7:0] y);
        bus.start = 1'b1;
        bus.x_in = x;
        tick();
        bus.start = 1'b0;
        bus.cfg_we = 1'b0;
        lat = 1;
        bcnt = 0;
        while (!bus.done && lat < 60) begin
            if (bus.busy) bcnt++;
            tick();
            lat++;
        end
        y = bus.y_out;
        tick();
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.x_in = 8'h00;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = 4'h0;
        bus.cfg_wdata = 12'h000;
        #12;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b want 0", bus.cfg_err); end
        checks++; if (bus.y_out !== 8'h00) begin errors++; $display("FAIL reset_y got %h want 00", bus.y_out); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_default();
        int lat, bcnt;
        logic [7:0] y;
        do_run(8'h5A, lat, bcnt, y);
        checks++; if (lat !== 17) begin errors++; $display("FAIL default_latency got %0d want 17", lat); end
        checks++; if (bcnt !== 16) begin errors++; $display("FAIL default_busy got %0d want 16", bcnt); end
        checks++; if (y !== 8'hFF) begin errors++; $display("FAIL default_y got %h want ff", y); end
    endtask

    task automatic test_config();
        int lat, bcnt;
        logic [7:0] y;
        for (int i = 0; i < 12; i++) cfg_write(4'(i), 12'h8FF);
        for (int i = 12; i < 16; i++) cfg_write(4'(i), 12'h4F0);
        do_run(8'hFF, lat, bcnt, y);
        checks++; if (y !== 8'hFF) begin errors++; $display("FAIL config_ff got %h want ff", y); end
        do_run(8'hFE, lat, bcnt, y);
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL config_fe got %h want 00", y); end
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 4'd12;
        bus.cfg_wdata = 12'h0F0;
        do_run(8'hFE, lat, bcnt, y);
        checks++; if (y !== 8'h10) begin errors++; $display("FAIL write_with_start got %h want 10", y); end
        cfg_write(4'd12, 12'h4F0);
        ena = 1'b0;
        cfg_write(4'd13, 12'hF00);
        ena = 1'b1;
        do_run(8'hFF, lat, bcnt, y);
        checks++; if (y !== 8'hFF) begin errors++; $display("FAIL frozen_write got %h want ff", y); end
    endtask

    task automatic test_cfg_err();
        int lat;
        bus.start = 1'b1;
        bus.x_in = 8'hFF;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        bus.cfg_we = 1'b1;
        bus.cfg_addr = 4'd12;
        bus.cfg_wdata = 12'hF00;
        checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_early got %b want 0", bus.cfg_err); end
        tick();
        bus.cfg_we = 1'b0;
        checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_pulse got %b want 1", bus.cfg_err); end
        tick();
        checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear got %b want 0", bus.cfg_err); end
        lat = 8;
        while (!bus.done && lat < 60) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 17) begin errors++; $display("FAIL cfg_err_latency got %0d want 17", lat); end
        checks++; if (bus.y_out !== 8'hFF) begin errors++; $display("FAIL cfg_err_y got %h want ff", bus.y_out); end
        tick();
    endtask

    task automatic test_ignored_start();
        int ndone = 0;
        int done_at = 0;
        int stray = 0;
        bus.start = 1'b1;
        bus.x_in = 8'hFF;
        tick();
        for (int c = 1; c <= 40; c++) begin
            bus.start = c == 3 || c == 10 || c == 17;
            if (bus.done) begin
                ndone++;
                done_at = c;
            end
            if (c >= 18 && bus.busy) stray++;
            tick();
        end
        bus.start = 1'b0;
        checks++; if (ndone !== 1) begin errors++; $display("FAIL ignored_done_count got %0d want 1", ndone); end
        checks++; if (done_at !== 17) begin errors++; $display("FAIL ignored_done_cycle got %0d want 17", done_at); end
        checks++; if (stray !== 0) begin errors++; $display("FAIL ignored_stray_busy got %0d want 0", stray); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        logic [7:0] y;
        do_run(8'hFF, lat, bcnt, y);
        checks++; if (y !== 8'hFF) begin errors++; $display("FAIL b2b_first_y got %h want ff", y); end
        do_run(8'hFE, lat, bcnt, y);
        checks++; if (lat !== 17 || bcnt !== 16) begin errors++; $display("FAIL b2b_second_timing got %0d/%0d want 17/16", lat, bcnt); end
        checks++; if (y !== 8'h00) begin errors++; $display("FAIL b2b_second_y got %h want 00", y); end
    endtask

    task automatic test_stall();
        int lat;
        bus.start = 1'b1;
        bus.x_in = 8'hFF;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL stall_hold got %b%b want 10", bus.busy, bus.done); end
            tick();
        end
        ena = 1'b1;
        lat = 15;
        while (!bus.done && lat < 60) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 22) begin errors++; $display("FAIL stall_latency got %0d want 22", lat); end
        checks++; if (bus.y_out !== 8'hFF) begin errors++; $display("FAIL stall_y got %h want ff", bus.y_out); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        logic [7:0] y;
        bus.start = 1'b1;
        bus.x_in = 8'hFF;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", bus.done); end
        checks++; if (bus.y_out !== 8'h00) begin errors++; $display("FAIL midreset_y got %h want 00", bus.y_out); end
        #3 rst_n = 1'b1;
        tick();
        do_run(8'hFE, lat, bcnt, y);
        checks++; if (lat !== 17) begin errors++; $display("FAIL postreset_latency got %0d want 17", lat); end
        checks++; if (y !== 8'hFF) begin errors++; $display("FAIL postreset_y got %h want ff", y); end
    endtask

    initial begin
        test_reset();
        test_default();
        test_config();
        test_cfg_err();
        test_ignored_start();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
